// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller: arbitrates the two commit slots and pending
// interrupts, strobes CP0 once per event and sequences the flush/redirect.
module exc_commit_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] EXC_OFFSET   = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        slot1_valid_i,
   input  logic        slot1_exc_i,
   input  logic [4:0]  slot1_code_i,
   input  logic        slot2_valid_i,
   input  logic        slot2_exc_i,
   input  logic [4:0]  slot2_code_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic [31:0] ebase_i,
   output logic        exception_flag_o,
   output logic [4:0]  exception_type_o,
   output logic        exception_first_inst_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_FLUSH} state_t;

   localparam logic [4:0] CODE_INT   = 5'd0;
   localparam logic [4:0] CODE_ERET  = 5'd14;
   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

   state_t      r_state;
   logic [2:0]  r_count;
   logic        r_flag;
   logic [4:0]  r_type;
   logic        r_first;
   logic        r_flush;
   logic [31:0] r_new_pc;
   logic [4:0]  r_hold_type;
   logic        r_hold_first;
   logic [31:0] r_hold_pc;

   logic        w_int_pending;
   logic        w_event;
   logic [4:0]  w_type;
   logic        w_first;
   logic [31:0] w_target;
   logic        w_launch;
   logic [4:0]  w_launch_type;
   logic        w_launch_first;
   logic [31:0] w_launch_pc;
   logic        w_unused;

   // Only IE, EXL and the IM/IP fields take part in interrupt detection.
   assign w_unused = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

   assign w_int_pending = status_i[0] & ~status_i[1] & (|(status_i[15:8] & cause_i[15:8]));

   // NOTE: every variable gets a default first so no path through the block infers a latch.
   always_comb begin
      w_event = 1'b0;
      w_type  = CODE_INT;
      w_first = 1'b1;
      if (w_int_pending && slot1_valid_i) begin
         w_event = 1'b1;
      end else if (slot1_valid_i && slot1_exc_i) begin
         w_event = 1'b1;
         w_type  = slot1_code_i;
      end else if (w_int_pending && slot2_valid_i) begin
         w_event = 1'b1;
         w_first = 1'b0;
      end else if (slot2_valid_i && slot2_exc_i) begin
         w_event = 1'b1;
         w_type  = slot2_code_i;
         w_first = 1'b0;
      end
   end

   assign w_target = (w_type == CODE_ERET) ? epc_i : ebase_i + EXC_OFFSET;

   // A fresh unstalled event and a held event released by the stall share one launch path.
   assign w_launch       = ~stall_i & (((r_state == ST_IDLE) & w_event) | (r_state == ST_HOLD));
   assign w_launch_type  = (r_state == ST_HOLD) ? r_hold_type  : w_type;
   assign w_launch_first = (r_state == ST_HOLD) ? r_hold_first : w_first;
   assign w_launch_pc    = (r_state == ST_HOLD) ? r_hold_pc    : w_target;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_count      <= 3'd0;
         r_flag       <= 1'b0;
         r_type       <= 5'd0;
         r_first      <= 1'b0;
         r_flush      <= 1'b0;
         r_new_pc     <= 32'd0;
         r_hold_type  <= 5'd0;
         r_hold_first <= 1'b0;
         r_hold_pc    <= 32'd0;
      end else if (w_launch) begin
         r_state  <= ST_FLUSH;
         r_count  <= FLUSH_LAST;
         r_flag   <= 1'b1;
         r_type   <= w_launch_type;
         r_first  <= w_launch_first;
         r_flush  <= 1'b1;
         r_new_pc <= w_launch_pc;
      end else begin
         r_flag <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_event) begin
                  r_state      <= ST_HOLD;
                  r_hold_type  <= w_type;
                  r_hold_first <= w_first;
                  r_hold_pc    <= w_target;
               end
            end
            ST_HOLD: ;
            ST_FLUSH: begin
               // Events arriving during the flush are dropped; the refetched pipeline re-raises them.
               if (r_count == 3'd0) begin
                  r_state <= ST_IDLE;
                  r_flush <= 1'b0;
               end else begin
                  r_count <= r_count - 3'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_flush <= 1'b0;
            end
         endcase
      end
   end

   assign exception_flag_o       = r_flag;
   assign exception_type_o       = r_type;
   assign exception_first_inst_o = r_first;
   assign flush_o                = r_flush;
   assign new_pc_o               = r_new_pc;
   assign busy_o                 = (r_state != ST_IDLE);

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: each task drives one scenario and checks
// hand-computed CP0 strobe, flush and redirect values.
module tb_exc_commit_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        slot1_valid_i = 1'b0, slot1_exc_i = 1'b0;
   logic [4:0]  slot1_code_i = 5'd0;
   logic        slot2_valid_i = 1'b0, slot2_exc_i = 1'b0;
   logic [4:0]  slot2_code_i = 5'd0;
   logic [31:0] status_i = 32'd0, cause_i = 32'd0, epc_i = 32'd0, ebase_i = 32'd0;
   logic        exception_flag_o, exception_first_inst_o, flush_o, busy_o;
   logic [4:0]  exception_type_o;
   logic [31:0] new_pc_o;

   int n_checks = 0;
   int n_fail   = 0;

   exc_commit_ctrl #(.FLUSH_CYCLES(2), .EXC_OFFSET(32'h0000_0180)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i),
      .slot1_valid_i(slot1_valid_i), .slot1_exc_i(slot1_exc_i), .slot1_code_i(slot1_code_i),
      .slot2_valid_i(slot2_valid_i), .slot2_exc_i(slot2_exc_i), .slot2_code_i(slot2_code_i),
      .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .ebase_i(ebase_i),
      .exception_flag_o(exception_flag_o), .exception_type_o(exception_type_o),
      .exception_first_inst_o(exception_first_inst_o), .flush_o(flush_o),
      .new_pc_o(new_pc_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle; inputs change and outputs are sampled 1ns after posedge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_slots();
      slot1_valid_i = 1'b0; slot1_exc_i = 1'b0; slot1_code_i = 5'd0;
      slot2_valid_i = 1'b0; slot2_exc_i = 1'b0; slot2_code_i = 5'd0;
      status_i = 32'd0; cause_i = 32'd0; stall_i = 1'b0;
   endtask

   task automatic drain();
      clr_slots();
      repeat (3) tick();
   endtask

   task automatic test_reset();
      clr_slots();
      rst = 1'b1;
      tick(); tick();
      n_checks++; if (exception_flag_o !== 1'b0) begin n_fail++; $display("FAIL reset_flag got=%b exp=0", exception_flag_o); end
      n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", flush_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      n_checks++; if (exception_type_o !== 5'd0 || exception_first_inst_o !== 1'b0) begin n_fail++; $display("FAIL reset_type got=%0d/%b exp=0/0", exception_type_o, exception_first_inst_o); end
      n_checks++; if (new_pc_o !== 32'd0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", new_pc_o); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      ebase_i = 32'hBFC0_0200;
      slot1_valid_i = 1'b1; slot1_exc_i = 1'b1; slot1_code_i = 5'd10;
      tick();
      n_checks++; if (exception_flag_o !== 1'b1) begin n_fail++; $display("FAIL basic_flag got=%b exp=1", exception_flag_o); end
      n_checks++; if (exception_type_o !== 5'd10 || exception_first_inst_o !== 1'b1) begin n_fail++; $display("FAIL basic_type got=%0d/%b exp=10/1", exception_type_o, exception_first_inst_o); end
      n_checks++; if (flush_o !== 1'b1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_flush1 got=%b/%b exp=1/1", flush_o, busy_o); end
      n_checks++; if (new_pc_o !== 32'hBFC0_0380) begin n_fail++; $display("FAIL basic_pc got=%h exp=bfc00380", new_pc_o); end
      clr_slots();
      tick();
      n_checks++; if (exception_flag_o !== 1'b0 || flush_o !== 1'b1) begin n_fail++; $display("FAIL basic_flush2 got flag=%b flush=%b exp 0/1", exception_flag_o, flush_o); end
      n_checks++; if (new_pc_o !== 32'hBFC0_0380 || exception_type_o !== 5'd10) begin n_fail++; $display("FAIL basic_hold got=%h/%0d exp=bfc00380/10", new_pc_o, exception_type_o); end
      tick();
      n_checks++; if (flush_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_end got=%b/%b exp=0/0", flush_o, busy_o); end
      tick();
      n_checks++; if (exception_flag_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle_flag got=%b exp=0", exception_flag_o); end
   endtask

   task automatic test_priority();
      slot1_valid_i = 1'b1; slot2_valid_i = 1'b1; slot2_exc_i = 1'b1; slot2_code_i = 5'd12;
      tick();
      n_checks++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd12 || exception_first_inst_o !== 1'b0) begin n_fail++; $display("FAIL prio_slot2 got=%b/%0d/%b exp=1/12/0", exception_flag_o, exception_type_o, exception_first_inst_o); end
      drain();
      slot1_valid_i = 1'b1; slot1_exc_i = 1'b1; slot1_code_i = 5'd8;
      slot2_valid_i = 1'b1; slot2_exc_i = 1'b1; slot2_code_i = 5'd12;
      tick();
      n_checks++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd8 || exception_first_inst_o !== 1'b1) begin n_fail++; $display("FAIL prio_slot1 got=%b/%0d/%b exp=1/8/1", exception_flag_o, exception_type_o, exception_first_inst_o); end
      drain();
      slot1_exc_i = 1'b1; slot1_code_i = 5'd10; slot2_exc_i = 1'b1; slot2_code_i = 5'd12;
      tick();
      n_checks++; if (exception_flag_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL prio_invalid got=%b/%b exp=0/0", exception_flag_o, busy_o); end
      drain();
   endtask

   task automatic test_interrupt();
      ebase_i = 32'h8000_0000;
      status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
      slot1_valid_i = 1'b1; slot1_exc_i = 1'b1; slot1_code_i = 5'd9;
      tick();
      n_checks++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd0 || exception_first_inst_o !== 1'b1) begin n_fail++; $display("FAIL int_slot1 got=%b/%0d/%b exp=1/0/1", exception_flag_o, exception_type_o, exception_first_inst_o); end
      n_checks++; if (new_pc_o !== 32'h8000_0180) begin n_fail++; $display("FAIL int_pc got=%h exp=80000180", new_pc_o); end
      drain();
      status_i = 32'h0000_0403; cause_i = 32'h0000_0400;
      slot1_valid_i = 1'b1; slot1_exc_i = 1'b1; slot1_code_i = 5'd9;
      tick();
      n_checks++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd9) begin n_fail++; $display("FAIL int_exl got=%b/%0d exp=1/9", exception_flag_o, exception_type_o); end
      drain();
      status_i = 32'h0000_0401; cause_i = 32'h0000_0400; slot2_valid_i = 1'b1;
      tick();
      n_checks++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd0 || exception_first_inst_o !== 1'b0) begin n_fail++; $display("FAIL int_slot2 got=%b/%0d/%b exp=1/0/0", exception_flag_o, exception_type_o, exception_first_inst_o); end
      drain();
   endtask

   task automatic test_eret();
      epc_i = 32'h8000_1000; ebase_i = 32'hBFC0_0200;
      slot1_valid_i = 1'b1; slot2_valid_i = 1'b1; slot2_exc_i = 1'b1; slot2_code_i = 5'd14;
      tick();
      n_checks++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd14 || exception_first_inst_o !== 1'b0) begin n_fail++; $display("FAIL eret_type got=%b/%0d/%b exp=1/14/0", exception_flag_o, exception_type_o, exception_first_inst_o); end
      n_checks++; if (new_pc_o !== 32'h8000_1000) begin n_fail++; $display("FAIL eret_pc got=%h exp=80001000", new_pc_o); end
      clr_slots();
      epc_i = 32'h0;
      tick();
      n_checks++; if (new_pc_o !== 32'h8000_1000 || flush_o !== 1'b1) begin n_fail++; $display("FAIL eret_stable got=%h/%b exp=80001000/1", new_pc_o, flush_o); end
      drain();
   endtask

   task automatic test_stall();
      ebase_i = 32'hBFC0_0200;
      stall_i = 1'b1;
      slot1_valid_i = 1'b1; slot1_exc_i = 1'b1; slot1_code_i = 5'd5;
      tick();
      n_checks++; if (busy_o !== 1'b1 || exception_flag_o !== 1'b0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL stall_hold got busy=%b flag=%b flush=%b exp 1/0/0", busy_o, exception_flag_o, flush_o); end
      slot1_valid_i = 1'b0; slot1_exc_i = 1'b0; ebase_i = 32'h0;
      slot2_valid_i = 1'b1; slot2_exc_i = 1'b1; slot2_code_i = 5'd12;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++; if (busy_o !== 1'b1 || exception_flag_o !== 1'b0) begin n_fail++; $display("FAIL stall_wait%0d got busy=%b flag=%b exp 1/0", i, busy_o, exception_flag_o); end
      end
      stall_i = 1'b0;
      tick();
      n_checks++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd5 || exception_first_inst_o !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b/%0d/%b exp=1/5/1", exception_flag_o, exception_type_o, exception_first_inst_o); end
      n_checks++; if (new_pc_o !== 32'hBFC0_0380 || flush_o !== 1'b1) begin n_fail++; $display("FAIL stall_pc got=%h/%b exp=bfc00380/1", new_pc_o, flush_o); end
      drain();
   endtask

   task automatic test_reset_mid_flush();
      slot1_valid_i = 1'b1; slot1_exc_i = 1'b1; slot1_code_i = 5'd4;
      tick();
      n_checks++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd4) begin n_fail++; $display("FAIL rstmid_first got=%b/%0d exp=1/4", exception_flag_o, exception_type_o); end
      clr_slots();
      tick();
      n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_flush2 got=%b exp=1", flush_o); end
      rst = 1'b1;
      tick();
      n_checks++; if (flush_o !== 1'b0 || busy_o !== 1'b0 || exception_flag_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort got flush=%b busy=%b flag=%b exp 0/0/0", flush_o, busy_o, exception_flag_o); end
      n_checks++; if (exception_type_o !== 5'd0) begin n_fail++; $display("FAIL rstmid_type got=%0d exp=0", exception_type_o); end
      rst = 1'b0;
      tick();
      n_checks++; if (exception_flag_o !== 1'b0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got=%b/%b exp=0/0", exception_flag_o, flush_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_interrupt();
      test_eret();
      test_stall();
      test_reset_mid_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Exception/interrupt commit controller for the dual-issue pipeline. It sits between the commit stage and the CP0 register file.
- Each cycle it arbitrates the exceptions raised by commit slot 1 and slot 2, folds in pending interrupts, and picks one event.
- It drives CP0's exception-commit inputs (flag, type, first-inst select) and sequences the pipeline flush and fetch redirect to the handler or to EPC.
- When a memory stall is active, it holds the event until the stall clears.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_o stays high per event (1..7).
- EXC_OFFSET, 32'h0000_0180, handler offset added to ebase_i.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall_i  in  1  memory/cache stall; no exception may commit while high
- slot1_valid_i  in  1  slot 1 holds a committing instruction
- slot1_exc_i  in  1  slot 1 raised an exception
- slot1_code_i  in  5  slot 1 ExcCode (4 ADEL, 5 ADES, 8 SYS, 9 BP, 10 RI, 12 OV, 13 TR, 14 ERET)
- slot2_valid_i  in  1  slot 2 holds a committing instruction
- slot2_exc_i  in  1  slot 2 raised an exception
- slot2_code_i  in  5  slot 2 ExcCode, same encoding
- status_i  in  32  CP0 Status
- cause_i  in  32  CP0 Cause
- epc_i  in  32  CP0 EPC
- ebase_i  in  32  CP0 EBase
- exception_flag_o  out  1  one-cycle commit strobe to CP0
- exception_type_o  out  5  ExcCode to CP0 (0 = INT)
- exception_first_inst_o  out  1  1 = slot 1 excepted, 0 = slot 2
- flush_o  out  1  pipeline flush
- new_pc_o  out  32  redirect target, valid while flush_o is high
- busy_o  out  1  high in HOLD or FLUSH; upstream must not commit

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE, all outputs 0, flush counter 0. Reset mid-HOLD or mid-FLUSH aborts the event with no CP0 strobe.
- int_pending = status_i[0] & ~status_i[1] & |(status_i[15:8] & cause_i[15:8]).
- Event select, combinational, evaluated only in IDLE, first match wins:
  - int_pending & slot1_valid -> INT, first=1
  - slot1_valid & slot1_exc -> slot1_code, first=1
  - int_pending & ~slot1_valid & slot2_valid -> INT, first=0
  - slot2_valid & slot2_exc -> slot2_code, first=0
  - otherwise no event
- An invalid slot's exc/code is ignored. Slot 2 is never chosen while slot 1 is valid and excepting.
- Target: code 14 -> epc_i; else ebase_i + EXC_OFFSET, 32-bit wrap. The target is sampled in the detection cycle.
- IDLE:
  - Event and ~stall_i -> FLUSH. Next cycle: exception_flag_o=1 for exactly 1 cycle, type/first registered, flush_o=1, new_pc_o=target, counter=FLUSH_CYCLES-1.
  - Event and stall_i -> HOLD. Latch type, first and target.
- HOLD:
  - busy_o=1, all slot inputs ignored.
  - When stall_i=0 -> FLUSH using the latched values. The strobe fires the cycle after the stall drops.
- FLUSH:
  - flush_o=1, new_pc_o stable, exception_flag_o=0 after its first cycle.
  - Counter decrements; at 0 -> IDLE with flush_o=0 the next cycle.
  - New events in FLUSH are dropped; the flushed pipeline re-presents them.
  - stall_i is ignored in FLUSH.
- Latency: detection to strobe/flush is 1 cycle with no stall; 1 cycle after stall release otherwise.
- ERET (14) is passed to CP0 as type 14. CP0 clears Status.EXL.
- busy_o = (state != IDLE).
- exception_type_o and exception_first_inst_o hold their last value outside the strobe cycle; they reset to 0.

Test Plan:
- Slot1 valid, exc=1, code=10, ebase_i=32'hBFC0_0200, no stall -> next cycle flag=1, type=10, first=1, flush_o=1 for 2 cycles, new_pc_o=32'hBFC0_0380, then IDLE.
- Slot1 valid with no exception, slot2 exc code 12 -> type=12, first=0; the same stimulus with slot1 exc code 8 as well -> type=8, first=1.
- status_i=32'h0000_0401, cause_i=32'h0000_0400, slot1 valid with exc code 9 -> type=0 (INT), first=1; with status_i[1]=1 -> type=9.
- Slot2 exc code 14, epc_i=32'h8000_1000 -> flag, type=14, new_pc_o=32'h8000_1000.
- stall_i held high 3 cycles while slot1 exc code 5 -> busy_o=1, no flag; flag fires the cycle after stall_i falls with type=5.
- rst asserted during the 2nd FLUSH cycle -> the next cycle flush_o=0, busy_o=0, no further flag.
